// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The master side requests operations; the slave side returns results.
interface serial_subtractor_if #(
   parameter int BIT_WIDTH = 8
);
   logic                 start;
   logic [BIT_WIDTH-1:0] a;
   logic [BIT_WIDTH-1:0] b;
   logic                 borrow_in;
   logic                 busy;
   logic                 done;
   logic [BIT_WIDTH-1:0] diff;
   logic                 borrow_out;
   logic                 overflow;

   modport master (
      output start, a, b, borrow_in,
      input  busy, done, diff, borrow_out, overflow
   );

   modport slave (
      input  start, a, b, borrow_in,
      output busy, done, diff, borrow_out, overflow
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, one bit per clock,
// LSB first. Results are registered and held until the next operation completes.
module serial_subtractor #(
   parameter int BIT_WIDTH = 8
) (
   input  logic                clk,
   input  logic                n_rst,
   serial_subtractor_if.slave  bus
);
   localparam int                 CNT_W    = $clog2(BIT_WIDTH);
   localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(BIT_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state;
   logic [BIT_WIDTH-1:0] a_sr;
   logic [BIT_WIDTH-1:0] b_sr;
   logic [BIT_WIDTH-1:0] res_sr;
   logic                 a_msb;
   logic                 b_msb;
   logic                 br;
   logic [CNT_W-1:0]     bit_cnt;

   logic                 d_bit;
   logic                 br_next;
   logic [BIT_WIDTH-1:0] res_next;

   // Full-subtractor cell on the current LSBs of the operand shift registers
   always_comb begin
      d_bit    = a_sr[0] ^ b_sr[0] ^ br;
      br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
      res_next = {d_bit, res_sr[BIT_WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state          <= IDLE;
         a_sr           <= '0;
         b_sr           <= '0;
         res_sr         <= '0;
         a_msb          <= 1'b0;
         b_msb          <= 1'b0;
         br             <= 1'b0;
         bit_cnt        <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.diff       <= '0;
         bus.borrow_out <= 1'b0;
         bus.overflow   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_sr     <= bus.a;
                  b_sr     <= bus.b;
                  a_msb    <= bus.a[BIT_WIDTH-1];
                  b_msb    <= bus.b[BIT_WIDTH-1];
                  br       <= bus.borrow_in;
                  res_sr   <= '0;
                  bit_cnt  <= '0;
                  bus.busy <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               res_sr  <= res_next;
               br      <= br_next;
               bit_cnt <= bit_cnt + 1'b1;
               // The MSB is processed on the last bit, so d_bit is the result sign here
               if (bit_cnt == LAST_BIT) begin
                  bus.diff       <= res_next;
                  bus.borrow_out <= br_next;
                  bus.overflow   <= (a_msb != b_msb) && (d_bit != a_msb);
                  bus.done       <= 1'b1;
                  state          <= DONE;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor. It computes diff = a - b - borrow_in one bit per clock, LSB first, under a start/busy/done handshake. It is the inverse-operation companion to the team's ripple-carry adder path, used where area matters more than latency. Results are registered and held until the next operation completes.

Parameters:
BIT_WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  system clock, rising-edge active
n_rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  BIT_WIDTH  minuend; captured on accepted start
b  input  BIT_WIDTH  subtrahend; captured on accepted start
borrow_in  input  1  initial borrow; captured on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
diff  output  BIT_WIDTH  registered result
borrow_out  output  1  final borrow (unsigned a < b + borrow_in)
overflow  output  1  signed overflow of the subtraction

Behaviour:
- Reset: asynchronous on n_rst low.
  - State = IDLE.
  - busy = 0, done = 0, diff = 0, borrow_out = 0, overflow = 0.
  - Internal operand/shift registers, borrow flop and bit counter cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - start = 1 at an edge: latch a, b and borrow_in into internal registers; bit counter = 0; go to CALC.
  - start = 0: stay in IDLE.
  - a, b and borrow_in are don't-care after capture.
- CALC: at each edge, process bit i = counter.
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - Shift d_i into the result shift register MSB side, right-shifting so that bit 0 ends in position 0.
  - Counter increments by 1.
- Last bit (counter == BIT_WIDTH-1), at the same edge:
  - diff is loaded with the full result.
  - borrow_out = br_next.
  - overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]).
  - Go to DONE.
- DONE: done = 1 for exactly this one cycle; next edge returns to IDLE.
- Latency: start accepted at edge E0. Bits are processed at edges E1..E(BIT_WIDTH). done is high between edges E(BIT_WIDTH) and E(BIT_WIDTH+1). For BIT_WIDTH = 8, done is high in the 9th cycle after the accepting edge.
- Back-to-back: the earliest next acceptance is the edge that leaves DONE+1, i.e. the first edge seen in IDLE. Throughput is 1 operation per BIT_WIDTH+2 cycles.
- start while busy (CALC or DONE): ignored. No queueing, no error flag, no effect on the operation in flight.
- Output hold: diff, borrow_out and overflow change only at the completion edge. They are stable through IDLE and CALC of the next operation.
- Reset mid-operation: immediate abort; all outputs return to reset values; no done pulse for the aborted operation.
- borrow_out is the unsigned borrow. overflow is signed (two's complement); the two are independent.
- Counter width is $clog2(BIT_WIDTH). No combinational path from any input to any output.

Test Plan:
- Reset then idle: n_rst low mid-run with a = 8'hFF, b = 8'h01 -> busy/done/diff/borrow_out/overflow all 0 immediately (asynchronous); idle for 5 cycles with start = 0 -> outputs stay 0.
- Basic subtraction: a = 8'h05, b = 8'h03, borrow_in = 0, start pulsed 1 cycle -> busy high for 9 cycles; done single pulse 9 cycles after the accept edge; diff = 8'h02, borrow_out = 0, overflow = 0.
- Borrow and borrow_in cases:
  - a = 8'h00, b = 8'h01 -> diff = 8'hFF, borrow_out = 1, overflow = 0.
  - a = 8'h10, b = 8'h0F, borrow_in = 1 -> diff = 8'h00, borrow_out = 0, overflow = 0.
- Signed overflow:
  - a = 8'h80, b = 8'h01 -> diff = 8'h7F, borrow_out = 0, overflow = 1.
  - a = 8'h7F, b = 8'hFF -> diff = 8'h80, borrow_out = 1, overflow = 1.
- Handshake abuse:
  - Hold start = 1 continuously with changing a/b -> operations accepted only on IDLE edges, one every 10 cycles, each result matching operands present at its accept edge.
  - A start pulse in mid-CALC -> ignored; current result unaffected.
  - Previous diff held unchanged during the next CALC.
- Abort: assert n_rst low at CALC bit 4 of a = 8'h05, b = 8'h03 -> no done pulse, diff = 0. Then a = 8'h20, b = 8'h10 -> diff = 8'h10 correctly.
